// File: rtl/lsf_rom_addr_gen.sv
// lsf_rom_addr_gen: round-robin arbiter feeding a two-stage pipeline that
// turns a per-channel angle (global theta or local slice-vector offset)
// into a clamped LUT start address and ROM bank index.
module lsf_rom_addr_gen #(
  parameter int NUM_CH              = 4,
  parameter int ANG_W               = 12,
  parameter int VEC_ANG_W           = 10,
  parameter int HEG_SHIFT           = 2,
  parameter int HALF_PI_MRAD        = 1571,
  parameter int ANGLE_MAX_HALF_MRAD = 500,
  parameter int BIN_CENTER_MRAD     = 100,
  parameter int RES_INV             = 64,
  parameter int LUT_SHIFT           = 6,
  parameter int ADDR_OFFSET         = 10,
  parameter int LUT_ADDR_W          = 10,
  parameter int ROM_IDX_W           = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_CH-1:0]                            in_vld,
  output logic [NUM_CH-1:0]                            in_rdy,
  input  logic [NUM_CH-1:0]                            lbins0_gbl1,
  input  logic [NUM_CH*ANG_W-1:0]                      theta_for_lut,
  input  logic [NUM_CH*VEC_ANG_W-1:0]                  slcvec_offset_angle_int,
  output logic                                         out_vld,
  input  logic                                         out_rdy,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic [LUT_ADDR_W-1:0]                        lut_start_addr,
  output logic [ROM_IDX_W-1:0]                         rom_index,
  output logic [ANG_W-1:0]                             slcvec_angle_mrad,
  output logic                                         addr_oor
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW   = ANG_W + 2;
  localparam logic signed [63:0] ADDR_MAX = (64'sd1 <<< LUT_ADDR_W) - 64'sd1;

  // Arbiter / stage registers
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [CH_W-1:0]       s1_ch_q, s1_ch_d;
  logic [ANG_W-1:0]      s1_ang_q, s1_ang_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [CH_W-1:0]       s2_ch_q, s2_ch_d;
  logic [ANG_W-1:0]      s2_ang_q, s2_ang_d;
  logic [LUT_ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic                  s2_oor_q, s2_oor_d;

  // Combinational helpers
  logic                  gnt_found;
  logic [CH_W-1:0]       gnt_ch;
  logic                  s1_adv, s2_adv, gnt_fire;
  logic [ANG_W-1:0]      sel_theta, loc_ang, sel_ang;
  logic [VEC_ANG_W-1:0]  sel_off;
  logic signed [DW-1:0]  diff;
  logic signed [63:0]    raw;
  logic [LUT_ADDR_W-1:0] addr_c;
  logic                  oor_c;

  // A stage may load when it is empty or its contents move on this cycle
  assign s2_adv   = !s2_vld_q || out_rdy;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign gnt_fire = gnt_found && s1_adv;

  // Round-robin search: first requesting channel at or after rr_ptr
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_found && in_vld[CH_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_ch    = CH_W'(idx);
      end
    end
  end

  // One-hot accept, held low during reset
  always_comb begin
    in_rdy = '0;
    if (gnt_fire && rst) in_rdy[gnt_ch] = 1'b1;
  end

  // Stage-1 angle selection; local angle wraps modulo 2^ANG_W
  always_comb begin
    sel_theta = theta_for_lut[gnt_ch*ANG_W +: ANG_W];
    sel_off   = slcvec_offset_angle_int[gnt_ch*VEC_ANG_W +: VEC_ANG_W];
    loc_ang   = (ANG_W'(sel_off) << HEG_SHIFT) - ANG_W'(HALF_PI_MRAD)
                - ANG_W'(ANGLE_MAX_HALF_MRAD);
    sel_ang   = lbins0_gbl1[gnt_ch] ? sel_theta : loc_ang;
  end

  // Stage-2 address arithmetic in 64-bit signed, then clamp to LUT range
  always_comb begin
    diff   = $signed({2'b00, s1_ang_q}) - $signed(DW'(BIN_CENTER_MRAD));
    raw    = ((64'(diff) * 64'(RES_INV)) >>> LUT_SHIFT) + 64'(ADDR_OFFSET);
    addr_c = raw[LUT_ADDR_W-1:0];
    oor_c  = 1'b0;
    if (raw < 64'sd0) begin
      addr_c = '0;
      oor_c  = 1'b1;
    end else if (raw > ADDR_MAX) begin
      addr_c = '1;
      oor_c  = 1'b1;
    end
  end

  // Next-state for pointer and both pipeline stages
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    s1_vld_d  = s1_vld_q;
    s1_ch_d   = s1_ch_q;
    s1_ang_d  = s1_ang_q;
    s2_vld_d  = s2_vld_q;
    s2_ch_d   = s2_ch_q;
    s2_ang_d  = s2_ang_q;
    s2_addr_d = s2_addr_q;
    s2_oor_d  = s2_oor_q;
    if (gnt_fire) begin
      rr_ptr_d = (32'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
    end
    if (s1_adv) begin
      s1_vld_d = gnt_fire;
      if (gnt_fire) begin
        s1_ch_d  = gnt_ch;
        s1_ang_d = sel_ang;
      end
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_ch_d   = s1_ch_q;
        s2_ang_d  = s1_ang_q;
        s2_addr_d = addr_c;
        s2_oor_d  = oor_c;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_ch_q   <= '0;
      s1_ang_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_ch_q   <= '0;
      s2_ang_q  <= '0;
      s2_addr_q <= '0;
      s2_oor_q  <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_ch_q   <= s1_ch_d;
      s1_ang_q  <= s1_ang_d;
      s2_vld_q  <= s2_vld_d;
      s2_ch_q   <= s2_ch_d;
      s2_ang_q  <= s2_ang_d;
      s2_addr_q <= s2_addr_d;
      s2_oor_q  <= s2_oor_d;
    end
  end

  assign out_vld           = s2_vld_q;
  assign out_ch            = s2_ch_q;
  assign slcvec_angle_mrad = s2_ang_q;
  assign lut_start_addr    = s2_addr_q;
  assign addr_oor          = s2_oor_q;
  assign rom_index         = s2_addr_q[ROM_IDX_W-1:0];

endmodule

// File: doc/lsf_rom_addr_gen.md
LSF_ROM_ADDR_GEN -- requirements
Module: lsf_rom_addr_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of input channels (1..16).
REQ-002 SHALL have parameter ANG_W, default 12: width of the angle fields, in mrad units.
REQ-003 SHALL have parameter VEC_ANG_W, default 10: width of the slice-vector offset angle.
REQ-004 SHALL have parameter HEG_SHIFT, default 2: left shift applied to the offset angle in local mode.
REQ-005 SHALL have parameter HALF_PI_MRAD, default 1571, and ANGLE_MAX_HALF_MRAD, default 500: local-mode subtrahends.
REQ-006 SHALL have parameter BIN_CENTER_MRAD, default 100: angle-bin centre offset.
REQ-007 SHALL have parameter RES_INV, default 64, and LUT_SHIFT, default 6: bin scale multiplier and right shift.
REQ-008 SHALL have parameter ADDR_OFFSET, default 10; LUT_ADDR_W, default 10; ROM_IDX_W, default 3.
REQ-009 SHALL have port clk, input, 1 bit: the single clock.
REQ-010 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port in_vld, input, NUM_CH bits: per-channel request valid.
REQ-012 SHALL have port in_rdy, output, NUM_CH bits: per-channel accept, one-hot or zero.
REQ-013 SHALL have port lbins0_gbl1, input, NUM_CH bits: per-channel mode (0 = local, 1 = global).
REQ-014 SHALL have port theta_for_lut, input, NUM_CH*ANG_W bits: global angle, channel c at bits [c*ANG_W +: ANG_W].
REQ-015 SHALL have port slcvec_offset_angle_int, input, NUM_CH*VEC_ANG_W bits: offset angle, packed the same way.
REQ-016 SHALL have port out_vld, input out_rdy, output 1 bit each: output handshake.
REQ-017 SHALL have port out_ch, output, $clog2(NUM_CH) bits (minimum 1): source channel of the result.
REQ-018 SHALL have port lut_start_addr, output, LUT_ADDR_W bits, and rom_index, output, ROM_IDX_W bits.
REQ-019 SHALL have port slcvec_angle_mrad, output, ANG_W bits: the selected angle.
REQ-020 SHALL have port addr_oor, output, 1 bit: set when the address was clamped.

Function
REQ-021 SHALL arbitrate round-robin: grant the lowest c at or after rr_ptr (modulo NUM_CH) with in_vld[c]=1; after a grant, rr_ptr = c+1 modulo NUM_CH.
REQ-022 SHALL assert in_rdy[c] only in the cycle channel c is granted and stage 1 can accept; a transfer occurs when in_vld[c] and in_rdy[c] are both 1.
REQ-023 SHALL, in stage 1 (registered), compute angle = lbins0_gbl1[c] ? theta : ((offset << HEG_SHIFT) - HALF_PI_MRAD - ANGLE_MAX_HALF_MRAD), truncated to ANG_W bits, and carry the channel id.
REQ-024 SHALL, in stage 2 (registered), compute diff = angle - BIN_CENTER_MRAD as a signed value of ANG_W+2 bits.
REQ-025 SHALL, in stage 2, compute raw = ((diff*RES_INV) >>> LUT_SHIFT) + ADDR_OFFSET with full-width signed arithmetic and no intermediate truncation.
REQ-026 SHALL clamp: raw < 0 gives address 0 with addr_oor=1; raw > 2^LUT_ADDR_W-1 gives address 2^LUT_ADDR_W-1 with addr_oor=1; otherwise address = raw with addr_oor=0.
REQ-027 SHALL drive rom_index = lut_start_addr[ROM_IDX_W-1:0] combinationally.
REQ-028 SHALL have a latency of 2 cycles from the transfer edge to out_vld=1 when there is no backpressure, and a sustained throughput of 1 result per cycle.
REQ-029 SHALL hold all output fields stable while out_vld=1 and out_rdy=0.
REQ-030 SHALL stall stages 1 and 2 under backpressure, deassert all in_rdy bits when full, and never drop or duplicate a result.
REQ-031 SHALL leave rr_ptr unchanged when no channel is granted.
REQ-032 SHALL, when stage 2 is full and out_rdy=1, allow stage 1 to advance and accept a new grant in the same cycle.

Reset
REQ-033 SHALL, while rst=0 (asynchronous), clear rr_ptr, all stage valids, out_vld, in_rdy, out_ch, lut_start_addr, slcvec_angle_mrad and addr_oor to 0.
REQ-034 SHALL discard any in-flight results on reset, and SHALL accept its first request in the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover global mode: ch1, theta=300, out_rdy=1 -> 2 cycles later out_ch=1, lut_start_addr=210, rom_index=2, addr_oor=0.
REQ-036 SHALL cover local mode: ch0, offset=700 -> slcvec_angle_mrad=729, lut_start_addr=639, rom_index=7, addr_oor=0.
REQ-037 SHALL cover clamping: theta=50 -> lut_start_addr=0, addr_oor=1; theta=4000 -> lut_start_addr=1023, addr_oor=1.
REQ-038 SHALL cover fairness: all in_vld held high, out_rdy=1 -> grants in order 0,1,2,3,0 with one result per cycle.
REQ-039 SHALL cover backpressure: out_rdy=0 for 5 cycles with 4 requests pending -> outputs frozen, in_rdy=0 once full; after release, 4 results in order with none lost.
REQ-040 SHALL cover reset mid-operation: rst pulsed low with 2 results in flight -> out_vld=0 immediately; no stale result appears after release.
